// File: rtl/fpu_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter_if
// Brief    : Client request/response bus plus shared-FPU handshake bundle.
// Revision : 1.0
// ============================================================================
interface fpu_arbiter_if #(
    parameter int BITNESS    = 32,
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0]         req_valid;
    logic [REQUESTERS-1:0]         req_ready;
    logic [REQUESTERS*BITNESS-1:0] req_data_a;
    logic [REQUESTERS*BITNESS-1:0] req_data_b;
    logic [REQUESTERS*4-1:0]       req_command;
    logic [REQUESTERS-1:0]         resp_valid;
    logic [REQUESTERS-1:0]         resp_ready;
    logic [BITNESS-1:0]            resp_result;
    logic                          resp_error;
    logic                          busy;
    logic [2:0]                    grant_id;
    logic                          fpu_input_rdy;
    logic                          fpu_input_ack;
    logic [BITNESS-1:0]            fpu_data_a;
    logic [BITNESS-1:0]            fpu_data_b;
    logic [3:0]                    fpu_command;
    logic                          fpu_output_rdy;
    logic                          fpu_output_ack;
    logic [BITNESS-1:0]            fpu_result;

    // Arbiter view
    modport slave (
        input  req_valid, req_data_a, req_data_b, req_command, resp_ready,
        input  fpu_input_ack, fpu_output_rdy, fpu_result,
        output req_ready, resp_valid, resp_result, resp_error, busy, grant_id,
        output fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command, fpu_output_ack
    );

    // Clients plus FPU view
    modport master (
        output req_valid, req_data_a, req_data_b, req_command, resp_ready,
        output fpu_input_ack, fpu_output_rdy, fpu_result,
        input  req_ready, resp_valid, resp_result, resp_error, busy, grant_id,
        input  fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command, fpu_output_ack
    );
endinterface
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Brief    : Round-robin sharing of one FPU among REQUESTERS clients, with a
//            watchdog that turns a hung FPU operation into an error response.
// Revision : 1.0
// ============================================================================
module fpu_arbiter #(
    parameter int BITNESS    = 32,
    parameter int REQUESTERS = 4,
    parameter int TIMEOUT    = 64
) (
    input  wire logic    clock,
    input  wire logic    reset,
    fpu_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                r_state;
    logic [2:0]            r_ptr;
    logic [WD_W-1:0]       r_wdog;
    logic [REQUESTERS-1:0] r_gnt_oh;

    logic [2:0]            w_grant;
    logic                  w_any;
    logic [REQUESTERS-1:0] w_grant_oh;
    logic [BITNESS-1:0]    w_sel_a;
    logic [BITNESS-1:0]    w_sel_b;
    logic [3:0]            w_sel_cmd;

    // Scan from the lowest priority (ptr itself) upwards so the last hit is
    // the first requester after ptr in wrap-around order.
    always_comb begin
        w_grant = 3'd0;
        w_any   = 1'b0;
        for (int k = REQUESTERS; k >= 1; k--) begin
            for (int j = 0; j < REQUESTERS; j++) begin
                if (bus.req_valid[j] && (((int'(r_ptr) + k) % REQUESTERS) == j)) begin
                    w_grant = 3'(j);
                    w_any   = 1'b1;
                end
            end
        end
    end

    assign w_grant_oh = {{(REQUESTERS-1){1'b0}}, 1'b1} << w_grant;

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cmd = '0;
        for (int j = 0; j < REQUESTERS; j++) begin
            if (w_grant == 3'(j)) begin
                w_sel_a   = bus.req_data_a[j*BITNESS +: BITNESS];
                w_sel_b   = bus.req_data_b[j*BITNESS +: BITNESS];
                w_sel_cmd = bus.req_command[j*4 +: 4];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_ptr              <= 3'(REQUESTERS - 1);
            r_wdog             <= '0;
            r_gnt_oh           <= '0;
            bus.req_ready      <= '0;
            bus.resp_valid     <= '0;
            bus.resp_result    <= '0;
            bus.resp_error     <= 1'b0;
            bus.busy           <= 1'b0;
            bus.grant_id       <= 3'd0;
            bus.fpu_input_rdy  <= 1'b0;
            bus.fpu_data_a     <= '0;
            bus.fpu_data_b     <= '0;
            bus.fpu_command    <= 4'd0;
            bus.fpu_output_ack <= 1'b0;
        end else begin
            bus.req_ready      <= '0;
            bus.fpu_output_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A result left over from a timed-out operation is drained
                    // first; the ack already in flight keeps it to one pulse.
                    if (bus.fpu_output_rdy && !bus.fpu_output_ack) begin
                        bus.fpu_output_ack <= 1'b1;
                    end else if (w_any) begin
                        r_ptr             <= w_grant;
                        r_gnt_oh          <= w_grant_oh;
                        bus.grant_id      <= w_grant;
                        bus.req_ready     <= w_grant_oh;
                        bus.fpu_data_a    <= w_sel_a;
                        bus.fpu_data_b    <= w_sel_b;
                        bus.fpu_command   <= w_sel_cmd;
                        bus.fpu_input_rdy <= 1'b1;
                        bus.busy          <= 1'b1;
                        r_state           <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (bus.fpu_input_ack) begin
                        bus.fpu_input_rdy <= 1'b0;
                        r_wdog            <= '0;
                        r_state           <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.fpu_output_rdy) begin
                        bus.resp_result    <= bus.fpu_result;
                        bus.resp_error     <= 1'b0;
                        bus.resp_valid     <= r_gnt_oh;
                        bus.fpu_output_ack <= 1'b1;
                        r_wdog             <= '0;
                        r_state            <= ST_RESPOND;
                    end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                        bus.resp_result <= '0;
                        bus.resp_error  <= 1'b1;
                        bus.resp_valid  <= r_gnt_oh;
                        r_wdog          <= '0;
                        r_state         <= ST_RESPOND;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end

                ST_RESPOND: begin
                    if (|(bus.resp_ready & r_gnt_oh)) begin
                        bus.resp_valid <= '0;
                        bus.busy       <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fpu_arbiter
// Brief    : Directed self-checking bench for fpu_arbiter with a toy FPU model.
// Revision : 1.0
// ============================================================================
module tb_fpu_arbiter;
    localparam int BW  = 32;
    localparam int NR  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_arbiter_if #(.BITNESS(BW), .REQUESTERS(NR)) bus ();

    fpu_arbiter #(.BITNESS(BW), .REQUESTERS(NR), .TIMEOUT(TMO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Toy FPU: an add of equal operands bumps the exponent, anything else is a hash.
    function automatic logic [BW-1:0] fmodel(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                             input logic [3:0] c);
        if (a == b && c == 4'd0) return a + 32'h0080_0000;
        return (a ^ {b[15:0], b[31:16]}) + {28'd0, c};
    endfunction

    logic [BW-1:0] ca [NR];
    logic [BW-1:0] cb [NR];
    logic [3:0]    cc [NR];

    always_comb begin
        bus.req_data_a  = '0;
        bus.req_data_b  = '0;
        bus.req_command = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_data_a[i*BW +: BW] = ca[i];
            bus.req_data_b[i*BW +: BW] = cb[i];
            bus.req_command[i*4 +: 4]  = cc[i];
        end
    end

    // FPU model
    bit            ack_imm    = 1'b1;
    int            resp_delay = 5;
    logic          ack_dly;
    int            ack_cnt;
    logic [BW-1:0] m_res;
    int            m_cnt;
    logic          m_busy;

    assign bus.fpu_input_ack = ack_imm ? bus.fpu_input_rdy : ack_dly;

    always @(posedge clk) begin
        if (rst) begin
            ack_dly            <= 1'b0;
            ack_cnt            <= 0;
            m_res              <= '0;
            m_cnt              <= 0;
            m_busy             <= 1'b0;
            bus.fpu_output_rdy <= 1'b0;
            bus.fpu_result     <= '0;
        end else begin
            if (bus.fpu_input_rdy && !ack_dly) begin
                if (ack_cnt == 1) begin
                    ack_dly <= 1'b1;
                    ack_cnt <= 0;
                end else begin
                    ack_cnt <= ack_cnt + 1;
                end
            end else begin
                ack_dly <= 1'b0;
                ack_cnt <= 0;
            end
            if (bus.fpu_output_rdy && bus.fpu_output_ack) begin
                bus.fpu_output_rdy <= 1'b0;
                bus.fpu_result     <= '0;
            end
            if (bus.fpu_input_rdy && bus.fpu_input_ack) begin
                m_res  <= fmodel(bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command);
                m_cnt  <= resp_delay;
                m_busy <= 1'b1;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    bus.fpu_output_rdy <= 1'b1;
                    bus.fpu_result     <= m_res;
                    m_busy             <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Passive monitor
    int irdy_cyc = 0;
    int oack_cyc = 0;
    int overlap  = 0;
    int grant_q[$];

    always @(negedge clk) begin
        if (bus.fpu_input_rdy === 1'b1) irdy_cyc++;
        if (bus.fpu_output_ack === 1'b1) oack_cyc++;
        if (bus.fpu_input_rdy === 1'b1 && bus.fpu_output_rdy === 1'b1) overlap++;
        for (int i = 0; i < NR; i++) begin
            if (bus.req_ready[i] === 1'b1) grant_q.push_back(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (bus.resp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        check("resp_seen", 64'(bus.resp_valid != '0), 64'd1);
    endtask

    task automatic ack_resp(input logic [NR-1:0] who);
        bus.resp_ready = who;
        tick();
        bus.resp_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_client(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b,
                              input logic [3:0] c);
        ca[i] = a;
        cb[i] = b;
        cc[i] = c;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic seen;
        logic [BW-1:0] held;

        bus.req_valid  = '0;
        bus.resp_ready = '0;
        for (int i = 0; i < NR; i++) set_client(i, '0, '0, 4'd0);
        do_reset();

        // Reset state
        check("rst_ctrl", {bus.req_ready, bus.resp_valid, bus.busy, bus.grant_id,
                           bus.fpu_input_rdy, bus.fpu_output_ack, bus.resp_error}, 64'd0);
        check("rst_data", {bus.fpu_data_a, bus.fpu_data_b}, 64'd0);
        check("rst_result", 64'(bus.resp_result), 64'd0);

        // Single request, client 2, immediate ack, FPU answers 5 cycles after ack
        irdy_cyc = 0; oack_cyc = 0;
        ack_imm = 1'b1; resp_delay = 5;
        set_client(2, 32'h3F80_0000, 32'h3F80_0000, 4'd0);
        bus.req_valid = 4'b0100;
        tick();
        check("t1_req_ready", 64'(bus.req_ready), 64'h4);
        check("t1_grant_id", 64'(bus.grant_id), 64'd2);
        check("t1_input_rdy", 64'(bus.fpu_input_rdy), 64'd1);
        check("t1_busy", 64'(bus.busy), 64'd1);
        bus.req_valid = '0;
        set_client(2, 32'hDEAD_BEEF, 32'h1234_5678, 4'd9);
        wait_resp(n);
        check("t1_latency", 64'(n), 64'd7);
        check("t1_resp_valid", 64'(bus.resp_valid), 64'h4);
        check("t1_result", 64'(bus.resp_result), 64'h4000_0000);
        check("t1_error", 64'(bus.resp_error), 64'd0);
        check("t1_fpu_a", 64'(bus.fpu_data_a), 64'h3F80_0000);
        check("t1_fpu_b", 64'(bus.fpu_data_b), 64'h3F80_0000);
        check("t1_fpu_cmd", 64'(bus.fpu_command), 64'd0);
        check("t1_irdy_one_cycle", 64'(irdy_cyc), 64'd1);
        check("t1_req_ready_pulses", 64'(grant_q.size()), 64'd1);
        ack_resp(4'b0100);
        check("t1_resp_clear", 64'(bus.resp_valid), 64'd0);
        check("t1_idle", 64'(bus.busy), 64'd0);
        check("t1_oack_pulses", 64'(oack_cyc), 64'd1);

        // Round-robin with all four clients, delayed input ack
        do_reset();
        ack_imm = 1'b0; resp_delay = 2;
        set_client(0, 32'h1111_0000, 32'h0000_00A0, 4'd1);
        set_client(1, 32'h2222_0000, 32'h0000_00B1, 4'd2);
        set_client(2, 32'h3333_0000, 32'h0000_00C2, 4'd3);
        set_client(3, 32'h4444_0000, 32'h0000_00D3, 4'd4);
        grant_q.delete();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_resp(n);
            check("rr_owner", 64'(bus.resp_valid), 64'd1 << exp_order[k]);
            check("rr_result", 64'(bus.resp_result),
                  64'(fmodel(ca[exp_order[k]], cb[exp_order[k]], cc[exp_order[k]])));
            check("rr_error", 64'(bus.resp_error), 64'd0);
            ack_resp(bus.resp_valid);
            if (k == 4) bus.req_valid = '0;
        end
        check("rr_grants", 64'(grant_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_order", (k < grant_q.size()) ? 64'(grant_q[k]) : 64'hFFFF, 64'(exp_order[k]));
        end

        // Response backpressure on client 1 while client 3 waits
        ack_imm = 1'b1; resp_delay = 3;
        set_client(1, 32'h0BAD_F00D, 32'h5555_AAAA, 4'd6);
        set_client(3, 32'h7777_1234, 32'h0F0F_0F0F, 4'd5);
        bus.req_valid = 4'b0010;
        n = 0;
        while (bus.req_ready[1] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("bp_grant1", 64'(bus.req_ready), 64'h2);
        bus.req_valid = 4'b1000;
        wait_resp(n);
        held = bus.resp_result;
        check("bp_result", 64'(held), 64'(fmodel(ca[1], cb[1], cc[1])));
        for (int k = 0; k < 10; k++) begin
            bus.resp_ready = 4'b1101;
            tick();
            check("bp_valid_hold", 64'(bus.resp_valid), 64'h2);
            check("bp_result_hold", 64'(bus.resp_result), 64'(held));
            check("bp_busy", 64'(bus.busy), 64'd1);
            check("bp_no_issue", 64'(bus.fpu_input_rdy), 64'd0);
        end
        ack_resp(4'b0010);
        check("bp_released", 64'(bus.resp_valid), 64'd0);
        tick();
        check("bp_grant3", 64'(bus.req_ready), 64'h8);
        bus.req_valid = '0;
        wait_resp(n);
        check("bp_owner3", 64'(bus.resp_valid), 64'h8);
        check("bp_result3", 64'(bus.resp_result), 64'(fmodel(ca[3], cb[3], cc[3])));
        ack_resp(4'b1000);

        // Watchdog timeout: FPU answers far too late
        resp_delay = 20;
        set_client(0, 32'hCAFE_0001, 32'h0000_0002, 4'd7);
        bus.req_valid = 4'b0001;
        tick();
        check("to_grant0", 64'(bus.req_ready), 64'h1);
        bus.req_valid = '0;
        tick();
        wait_resp(n);
        check("to_wait_cycles", 64'(n), 64'd8);
        check("to_owner", 64'(bus.resp_valid), 64'h1);
        check("to_error", 64'(bus.resp_error), 64'd1);
        check("to_result", 64'(bus.resp_result), 64'd0);
        ack_resp(4'b0001);

        // Late result arrives while idle: drained with one ack, grant follows a cycle later
        n = 0;
        while (bus.fpu_output_rdy !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("late_rdy_seen", 64'(bus.fpu_output_rdy), 64'd1);
        oack_cyc = 0;
        resp_delay = 3;
        set_client(2, 32'h0123_4567, 32'h89AB_CDEF, 4'd3);
        bus.req_valid = 4'b0100;
        tick();
        check("late_ack", 64'(bus.fpu_output_ack), 64'd1);
        check("late_no_grant", 64'(bus.req_ready), 64'd0);
        tick();
        check("late_grant", 64'(bus.req_ready), 64'h4);
        check("late_ack_pulse", 64'(bus.fpu_output_ack), 64'd0);
        check("late_ack_count", 64'(oack_cyc), 64'd1);
        bus.req_valid = '0;
        wait_resp(n);
        check("late_owner", 64'(bus.resp_valid), 64'h4);
        check("late_result", 64'(bus.resp_result), 64'(fmodel(ca[2], cb[2], cc[2])));
        check("late_error", 64'(bus.resp_error), 64'd0);
        ack_resp(4'b0100);

        // Result on the final watchdog cycle counts as success
        resp_delay = 7;
        set_client(1, 32'h00FF_00FF, 32'h1357_9BDF, 4'd8);
        bus.req_valid = 4'b0010;
        tick();
        check("edge_grant1", 64'(bus.req_ready), 64'h2);
        bus.req_valid = '0;
        tick();
        wait_resp(n);
        check("edge_wait_cycles", 64'(n), 64'd8);
        check("edge_error", 64'(bus.resp_error), 64'd0);
        check("edge_result", 64'(bus.resp_result), 64'(fmodel(ca[1], cb[1], cc[1])));
        ack_resp(4'b0010);

        // Reset while waiting on the FPU
        resp_delay = 20;
        set_client(3, 32'hFACE_0003, 32'h0000_0003, 4'd2);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ctrl", {bus.req_ready, bus.resp_valid, bus.busy, bus.grant_id,
                            bus.fpu_input_rdy, bus.fpu_output_ack, bus.resp_error}, 64'd0);
        check("mrst_data", {bus.fpu_data_a, bus.fpu_data_b}, 64'd0);
        check("mrst_cmd_result", {bus.fpu_command, bus.resp_result}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.resp_valid != '0) seen = 1'b1;
        end
        check("mrst_no_resp", 64'(seen), 64'd0);
        resp_delay = 1;
        set_client(0, 32'h0000_1000, 32'h0000_2000, 4'd1);
        set_client(2, 32'h0000_3000, 32'h0000_4000, 4'd2);
        bus.req_valid = 4'b0101;
        tick();
        check("mrst_grant0", 64'(bus.req_ready), 64'h1);
        check("mrst_grant_id", 64'(bus.grant_id), 64'd0);
        bus.req_valid = 4'b0100;
        wait_resp(n);
        check("mrst_latency", 64'(n), 64'd3);
        check("mrst_owner0", 64'(bus.resp_valid), 64'h1);
        check("mrst_result0", 64'(bus.resp_result), 64'(fmodel(ca[0], cb[0], cc[0])));
        ack_resp(4'b0001);
        tick();
        check("mrst_grant2", 64'(bus.req_ready), 64'h4);
        bus.req_valid = '0;
        wait_resp(n);
        check("mrst_owner2", 64'(bus.resp_valid), 64'h4);
        check("mrst_result2", 64'(bus.resp_result), 64'(fmodel(ca[2], cb[2], cc[2])));
        ack_resp(4'b0100);

        check("no_rdy_overlap", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
